// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit operation codes and the iterative ALU state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_NOP = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

endpackage : alu_pkg

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU operations; NOP, SRL and undefined codes yield zero here.
module alu_comb_ops
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o
);

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_ADD:  res_o = a_i + b_i;
            OP_SUB:  res_o = a_i - b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

endmodule : alu_comb_ops

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle ADD/SUB/XOR/NOP, one-bit-per-cycle logical right shift,
// valid/ready handshake on both sides with a registered result and zero flag.
module iter_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_signal,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic            zero_q, zero_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] comb_res;
    logic [SHW-1:0]  shamt;

    assign shamt = op_b[SHW-1:0];

    alu_comb_ops #(
        .XLEN (XLEN)
    ) u_comb_ops (
        .op_i  (alu_signal),
        .a_i   (op_a),
        .b_i   (op_b),
        .res_o (comb_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_DONE;
                    if (alu_signal == OP_SRL) begin
                        acc_d  = op_a;
                        zero_d = (op_a == '0);
                        cnt_d  = shamt;
                        if (shamt != '0) begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        acc_d  = comb_res;
                        zero_d = (comb_res == '0);
                    end
                end
            end
            ST_SHIFT: begin
                // Zero tracks the shifted value so it is valid the cycle DONE is entered.
                acc_d  = acc_q >> 1;
                zero_d = ((acc_q >> 1) == '0);
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = acc_q;
    assign zero      = zero_q;

endmodule : iter_alu

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_iter_alu;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_signal;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    int total;
    int bad;

    iter_alu #(
        .XLEN (XLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_signal (alu_signal),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_result(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [XLEN-1:0] b);
        if (op == 4'b0101) return int'(b[4:0]);
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check latency/result/zero, stall for 'stall' cycles while
    // presenting a junk request, then hand off and confirm return to IDLE.
    task automatic do_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input int stall);
        logic [XLEN-1:0] exp_r;
        int              n;
        int              lat;
        exp_r = ref_result(op, a, b);
        lat   = ref_latency(op, b);
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("in_ready_before", {31'd0, in_ready}, 32'd1);
        alu_signal = op;
        op_a       = a;
        op_b       = b;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
            tick();
            n++;
        end
        check_eq("latency", n, lat);
        check_eq("result", result, exp_r);
        check_eq("zero", {31'd0, zero}, {31'd0, exp_r == '0});
        for (int i = 0; i < stall; i++) begin
            in_valid   = 1'b1;
            alu_signal = 4'b0010;
            op_a       = $urandom;
            op_b       = $urandom;
            check_eq("in_ready_done", {31'd0, in_ready}, 32'd0);
            tick();
            check_eq("held_valid", {31'd0, out_valid}, 32'd1);
            check_eq("held_result", result, exp_r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("idle_after_handoff", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0] ops [6];
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        alu_signal = '0;
        op_a       = '0;
        op_b       = '0;
        out_ready  = 1'b0;
        ops = '{4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0000, 4'b1111};

        #12;
        check_eq("reset_result", result, 32'd0);
        check_eq("reset_flags", {29'd0, zero, out_valid, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("ready_after_reset", {31'd0, in_ready}, 32'd1);

        do_op(4'b0010, 32'd5, 32'd7, 0);
        do_op(4'b0110, 32'h10, 32'h10, 0);
        do_op(4'b0110, 32'h0, 32'h1, 0);
        do_op(4'b0101, 32'h8000_0000, 32'd31, 0);
        do_op(4'b0101, 32'h8000_0000, 32'h20, 0);
        do_op(4'b0100, 32'hF0F0, 32'hFFFF, 5);
        do_op(4'b1111, 32'd3, 32'd4, 0);
        do_op(4'b0000, 32'h1234, 32'h5678, 1);
        do_op(4'b0101, 32'h0000_0001, 32'd1, 0);

        // Reset in the middle of a 20-step shift.
        alu_signal = 4'b0101;
        op_a       = 32'hFFFF_FFFF;
        op_b       = 32'd20;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("midshift_busy", {30'd0, out_valid, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_flags", {30'd0, zero, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                if (out_valid) seen++;
                tick();
            end
            check_eq("no_stale_valid", seen, 0);
        end

        for (int t = 0; t < 150; t++) begin
            logic [XLEN-1:0] a;
            logic [XLEN-1:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            do_op(ops[$urandom_range(0, 5)], a, b, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_iter_alu

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL expose port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL expose port rst_n, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-004 The block SHALL expose port in_valid, input, 1, meaning an operation request is present.
REQ-005 The block SHALL expose port in_ready, output, 1, meaning the block can accept a request this cycle.
REQ-006 The block SHALL expose port alu_signal, input, 4, meaning the operation code: 0010 ADD, 0110 SUB, 0100 XOR, 0101 SRL, 0000 NOP.
REQ-007 The block SHALL expose ports op_a and op_b, input, XLEN each, meaning the source operands.
REQ-008 The block SHALL expose port out_valid, output, 1, meaning result and zero are valid.
REQ-009 The block SHALL expose port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-010 The block SHALL expose port result, output, XLEN, meaning the operation result.
REQ-011 The block SHALL expose port zero, output, 1, meaning result equals 0, used for branch-equal decisions.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT and DONE, and SHALL drive in_ready high only in IDLE.
REQ-013 The block SHALL accept a request on a rising edge where in_valid and in_ready are both high, capturing alu_signal, op_a and op_b.
REQ-014 On acceptance of ADD, SUB, XOR or NOP, the block SHALL register the result at that edge and enter DONE, so out_valid is high in the following cycle.
REQ-015 The block SHALL compute ADD as op_a+op_b and SUB as op_a-op_b, both modulo 2^XLEN with carries and overflow discarded.
REQ-016 The block SHALL compute XOR as op_a^op_b.
REQ-017 For NOP and any undefined code, the block SHALL produce result 0 and zero 1 with single-cycle latency.
REQ-018 For SRL, the shift amount k SHALL be op_b[$clog2(XLEN)-1:0], and the shift SHALL be logical, filling with zeros.
REQ-019 For SRL with k=0, the block SHALL load op_a unchanged and enter DONE at the acceptance edge.
REQ-020 For SRL with k>=1, the block SHALL load op_a into the accumulator, enter SHIFT, and shift right by exactly one bit per cycle, entering DONE at the k-th edge after acceptance.
REQ-021 While in SHIFT, the block SHALL hold out_valid low and in_ready low and SHALL ignore in_valid.
REQ-022 In DONE, the block SHALL hold result and zero stable until an edge where out_ready is high, then return to IDLE.
REQ-023 The block SHALL NOT accept a new request in the same cycle as a result handoff, so the minimum spacing between accepts is 2 cycles.
REQ-024 The block SHALL register zero together with result and SHALL NOT derive it combinationally from op_a or op_b.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state to IDLE, result to 0, zero to 0, out_valid to 0, and the shift counter to 0.
REQ-026 A reset asserted during SHIFT or DONE SHALL discard the in-flight operation, with no result delivered after reset release.
REQ-027 After rst_n deasserts, in_ready SHALL be high in the first cycle.

Structure
REQ-028 Shared package alu_pkg SHALL hold the 4-bit operation code constants (ADD, SUB, XOR, SRL, NOP) and the state enumeration, shared with the ALU control decoder.
REQ-029 One sub-module, alu_comb_ops, SHALL compute the single-cycle ADD, SUB, XOR and NOP results combinationally, while iter_alu owns the handshake, FSM and shifter.

Verification
REQ-030 Test ADD: op_a=5, op_b=7 accepted at edge N, out_ready=1 -> result=12 and zero=0 in the cycle after N, then the block returns to IDLE.
REQ-031 Test SUB: op_a=0x10, op_b=0x10 -> result=0 and zero=1; test op_a=0, op_b=1 -> result=0xFFFFFFFF and zero=0.
REQ-032 Test SRL: op_a=0x80000000, op_b=31 -> out_valid first high exactly 31 cycles after the cycle following acceptance, with result=1; op_b=0x20 (k=0) -> result=0x80000000 after 1 cycle.
REQ-033 Test backpressure: XOR with op_a=0xF0F0, op_b=0xFFFF and out_ready=0 for 5 cycles -> result=0x0F0F held stable, in_ready=0, and a new in_valid is ignored until the handoff.
REQ-034 Test reset mid-shift: SRL with k=20, rst_n pulsed low at cycle 10 -> outputs go to 0 immediately, no out_valid afterwards, and in_ready=1 after release.
REQ-035 Test an undefined code 1111 with op_a=3, op_b=4 -> result=0 and zero=1 after 1 cycle.
